// File: rtl/irq_status_ctrl.sv
// Interrupt latch/mask stage: captures single-cycle source pulses into sticky pending bits,
// masks them with a per-source enable, and exposes status through a small word register port.
module irq_status_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_pulse,
    input  logic               reg_wr_en,
    input  logic               reg_rd_en,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_rvalid,
    output logic               irq_out
);

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_ENABLE  = 2'd1,
        REG_MISSED  = 2'd2,
        REG_COUNT   = 2'd3
    } reg_idx_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] missed;
    logic [CNT_W-1:0]   count;

    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] enable_nxt;
    logic [NUM_SRC-1:0] missed_nxt;
    logic [CNT_W-1:0]   count_nxt;

    logic [NUM_SRC-1:0] w1c_pending;
    logic [NUM_SRC-1:0] w1c_missed;
    logic               enable_wr;
    logic               count_clr;
    logic               any_pulse;
    logic [31:0]        rd_word;
    reg_idx_t           reg_idx;

    // Only the word index is decoded; byte-lane bits and data bits above NUM_SRC are ignored.
    logic unused_bits;
    assign unused_bits = ^{reg_addr[1:0], reg_wdata};

    assign reg_idx   = reg_idx_t'(reg_addr[3:2]);
    assign any_pulse = |src_pulse;

    // Write decode: one strobe per register, qualified by reg_wr_en.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        w1c_pending = '0;
        w1c_missed  = '0;
        enable_wr   = 1'b0;
        count_clr   = 1'b0;
        if (reg_wr_en) begin
            case (reg_idx)
                REG_PENDING: w1c_pending = reg_wdata[NUM_SRC-1:0];
                REG_ENABLE:  enable_wr   = 1'b1;
                REG_MISSED:  w1c_missed  = reg_wdata[NUM_SRC-1:0];
                REG_COUNT:   count_clr   = 1'b1;
                default:     ;
            endcase
        end
    end

    // A new pulse always beats a W1C on the same bit. A pulse only counts as "missed"
    // when the bit stays pending across the edge, i.e. it was not being cleared.
    always_comb begin
        pending_nxt = (pending & ~w1c_pending) | src_pulse;
        missed_nxt  = (missed & ~w1c_missed) | (src_pulse & pending & ~w1c_pending);
        enable_nxt  = enable_wr ? reg_wdata[NUM_SRC-1:0] : enable;
    end

    // Saturating event counter; a clear coinciding with a pulse cycle restarts at one.
    always_comb begin
        count_nxt = count;
        if (count_clr) begin
            count_nxt    = '0;
            count_nxt[0] = any_pulse;
        end else if (any_pulse && (count != CNT_MAX)) begin
            count_nxt = count + CNT_W'(1);
        end
    end

    // Read mux works on the registered (pre-write) values; unused upper bits read zero.
    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_PENDING: rd_word[NUM_SRC-1:0] = pending;
            REG_ENABLE:  rd_word[NUM_SRC-1:0] = enable;
            REG_MISSED:  rd_word[NUM_SRC-1:0] = missed;
            REG_COUNT:   rd_word[CNT_W-1:0]   = count;
            default:     rd_word              = '0;
        endcase
    end

    // Status state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            pending <= '0;
            enable  <= '0;
            missed  <= '0;
            count   <= '0;
        end else begin
            pending <= pending_nxt;
            enable  <= enable_nxt;
            missed  <= missed_nxt;
            count   <= count_nxt;
        end
    end

    // irq_out is a pure register of the registered pending/enable, giving two-edge pulse latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_out <= 1'b0;
        end else begin
            irq_out <= |(pending & enable);
        end
    end

    // Read port: rdata loads only on a read strobe and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_rd_en;
            if (reg_rd_en) begin
                reg_rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_irq_status_ctrl.sv
// Self-checking bench for irq_status_ctrl: directed scenarios plus randomized traffic,
// compared each cycle against an integer-level reference model.
module tb_irq_status_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src_pulse = '0;
    logic        reg_wr_en = 1'b0;
    logic        reg_rd_en = 1'b0;
    logic [3:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        irq_out;

    int tests = 0;
    int fails = 0;

    // Reference model state (plain integers).
    int unsigned m_pending, m_enable, m_missed, m_count, m_rdata;
    bit          m_rvalid, m_irq;

    irq_status_ctrl #(.NUM_SRC(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_pulse  (src_pulse),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_reg(input int unsigned idx);
        case (idx)
            0:       return m_pending;
            1:       return m_enable;
            2:       return m_missed;
            default: return m_count;
        endcase
    endfunction

    task automatic model_reset();
        m_pending = 0; m_enable = 0; m_missed = 0; m_count = 0;
        m_rdata = 0; m_rvalid = 0; m_irq = 0;
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare outputs.
    task automatic step(input logic [3:0] pulse, input logic wr, input logic rd,
                        input logic [3:0] addr, input logic [31:0] wdata);
        int unsigned idx, p, wm, w1c_p, w1c_m;
        bit          next_irq;
        @(negedge clk);
        src_pulse = pulse; reg_wr_en = wr; reg_rd_en = rd; reg_addr = addr; reg_wdata = wdata;
        @(posedge clk);
        idx      = 32'(addr[3:2]);
        p        = 32'(pulse);
        wm       = wdata & 32'hF;
        next_irq = (m_pending & m_enable) != 0;
        if (rd) m_rdata = model_reg(idx);
        m_rvalid = rd;
        w1c_p    = (wr && idx == 0) ? wm : 0;
        w1c_m    = (wr && idx == 2) ? wm : 0;
        m_missed  = (m_missed & ~w1c_m) | (p & m_pending & ~w1c_p);
        m_pending = (m_pending & ~w1c_p) | p;
        if (wr && idx == 1) m_enable = wm;
        if (wr && idx == 3) m_count = (p != 0) ? 1 : 0;
        else if (p != 0 && m_count < 15) m_count = m_count + 1;
        m_irq = next_irq;
        #1;
        check("irq_out", 32'(irq_out), 32'(m_irq));
        check("rvalid", 32'(reg_rvalid), 32'(m_rvalid));
        check("rdata", reg_rdata, m_rdata);
        src_pulse = '0; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_addr = '0; reg_wdata = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
        step(4'h0, 1'b1, 1'b0, addr, data);
    endtask

    task automatic rd_reg(input logic [3:0] addr);
        step(4'h0, 1'b0, 1'b1, addr, 32'h0);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_irq", 32'(irq_out), 32'h0);
        check("rst_rvalid", 32'(reg_rvalid), 32'h0);
        check("rst_rdata", reg_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic capture and irq latency.
        wr_reg(4'h4, 32'h1);
        idle(2);
        step(4'h1, 1'b0, 1'b0, 4'h0, 32'h0);
        rd_reg(4'h0);
        check("tp1_pending", reg_rdata, 32'h1);
        check("tp1_irq", 32'(irq_out), 32'h1);
        rd_reg(4'hC);
        check("tp1_count", reg_rdata, 32'h1);

        // Masked source latches but does not interrupt until enabled.
        wr_reg(4'h0, 32'hF);
        idle(2);
        step(4'h4, 1'b0, 1'b0, 4'h0, 32'h0);
        idle(2);
        check("tp2_masked_irq", 32'(irq_out), 32'h0);
        rd_reg(4'h0);
        check("tp2_pending", reg_rdata, 32'h4);
        wr_reg(4'h4, 32'hFFFF_FFF5);
        idle(1);
        check("tp2_enable_irq", 32'(irq_out), 32'h1);
        rd_reg(4'h4);
        check("tp2_enable_rd", reg_rdata, 32'h5);

        // Missed event, then W1C of pending and missed.
        wr_reg(4'h0, 32'hF);
        wr_reg(4'h4, 32'h1);
        idle(2);
        step(4'h1, 1'b0, 1'b0, 4'h0, 32'h0);
        step(4'h1, 1'b0, 1'b0, 4'h0, 32'h0);
        rd_reg(4'h8);
        check("tp3_missed", reg_rdata, 32'h1);
        wr_reg(4'h0, 32'h1);
        idle(1);
        check("tp3_irq_clear", 32'(irq_out), 32'h0);
        wr_reg(4'h8, 32'h1);
        rd_reg(4'h8);
        check("tp3_missed_clr", reg_rdata, 32'h0);

        // Pulse beats a simultaneous W1C; read in the same cycle as a write sees old value.
        step(4'h1, 1'b0, 1'b0, 4'h0, 32'h0);
        idle(1);
        step(4'h1, 1'b1, 1'b1, 4'h0, 32'h1);
        check("tp4_rd_prewrite", reg_rdata, 32'h1);
        rd_reg(4'h0);
        check("tp4_pending", reg_rdata, 32'h1);
        rd_reg(4'h8);
        check("tp4_missed", reg_rdata, 32'h0);
        check("tp4_irq", 32'(irq_out), 32'h1);

        // Counter saturation and clear-with-pulse.
        wr_reg(4'hC, 32'h0);
        for (int i = 0; i < 20; i++) step(4'(1 << (i % 4)), 1'b0, 1'b0, 4'h0, 32'h0);
        rd_reg(4'hC);
        check("tp5_sat", reg_rdata, 32'hF);
        step(4'h2, 1'b1, 1'b0, 4'hC, 32'hDEAD_BEEF);
        rd_reg(4'hC);
        check("tp5_clr_pulse", reg_rdata, 32'h1);

        // Asynchronous reset mid-stream.
        wr_reg(4'h4, 32'hF);
        step(4'hF, 1'b0, 1'b0, 4'h0, 32'h0);
        idle(1);
        rd_reg(4'h0);
        check("tp6_pre_pending", reg_rdata, 32'hF);
        check("tp6_pre_irq", 32'(irq_out), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("tp6_async_irq", 32'(irq_out), 32'h0);
        check("tp6_async_rvalid", 32'(reg_rvalid), 32'h0);
        check("tp6_async_rdata", reg_rdata, 32'h0);
        model_reset();
        @(negedge clk);
        src_pulse = 4'hF;
        @(negedge clk);
        src_pulse = 4'h0;
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd_reg(4'(a * 4));
            check("tp6_post_rd", reg_rdata, 32'h0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            logic [3:0]  p;
            logic        w, r;
            logic [3:0]  ad;
            logic [31:0] wd;
            p  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            w  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 1) == 0);
            ad = 4'($urandom);
            wd = $urandom;
            step(p, w, r, ad, wd);
        end
        for (int a = 0; a < 4; a++) rd_reg(4'(a * 4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/irq_status_ctrl.md
Name: irq_status_ctrl

Overview:
Interrupt latch and mask stage directly downstream of the debounced edge-pulse generator. It captures single-cycle interrupt pulses from NUM_SRC sources into sticky pending bits and applies a per-source enable mask. It drives one registered level interrupt to the ARM processing system. A simple word register port lets the AXI4-Lite slave front-end read status and clear it with write-one-to-clear.

Parameters:
NUM_SRC, 4, number of pulse sources (1..32).
CNT_W, 16, width of the saturating accepted-event counter (1..32).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
src_pulse  input  NUM_SRC  single-cycle interrupt pulses, one bit per source, synchronous to clk.
reg_wr_en  input  1  register write strobe, one cycle per write.
reg_rd_en  input  1  register read strobe, one cycle per read.
reg_addr  input  4  byte address; only bits [3:2] are decoded.
reg_wdata  input  32  write data.
reg_rdata  output  32  read data, valid when reg_rvalid=1.
reg_rvalid  output  1  one-cycle read-data-valid pulse.
irq_out  output  1  level interrupt to the processor.

Behaviour:
- Reset (asynchronous, rst=1): pending=0, enable=0, missed=0, count=0, irq_out=0, reg_rvalid=0, reg_rdata=0.
- Register map (index = reg_addr[3:2]); unused upper bits read 0:
  - 0x0 PENDING [NUM_SRC-1:0]: write-one-to-clear (W1C).
  - 0x4 ENABLE [NUM_SRC-1:0]: read/write.
  - 0x8 MISSED [NUM_SRC-1:0]: W1C.
  - 0xC COUNT [CNT_W-1:0]: any write clears it; the write data is ignored.
- Pulse capture: src_pulse[i]=1 at edge N sets pending[i]; the new value is visible from N+1. Capture is independent of enable[i]. Masked sources still latch.
- Missed: src_pulse[i]=1 while pending[i] is already 1 sets missed[i].
- Simultaneous pulse and W1C on the same bit: the pulse wins. pending[i] stays 1, and missed[i] is not set by that pulse.
- Simultaneous W1C on missed[i] and a new missed event: set wins.
- Count:
  - +1 on each cycle where src_pulse has any bit set, regardless of how many bits.
  - Saturates at 2^CNT_W-1; no wrap.
  - A write to 0xC in the same cycle as a pulse cycle gives count=1.
- Writes: take effect at the edge where reg_wr_en=1. Bits of reg_wdata at and above NUM_SRC are ignored.
- irq_out: a register loaded each cycle with |(pending & enable), using the registered values.
  - A pulse at edge N makes irq_out high from edge N+1 to N+2 (2-edge latency from the pulse).
  - Deasserts one cycle after the last enabled pending bit is cleared or masked.
  - Writing ENABLE on an already-pending bit raises irq_out one cycle after the write.
- Reads:
  - reg_rd_en at edge N gives reg_rdata and reg_rvalid=1 during the cycle after N.
  - reg_rvalid is 0 otherwise; reg_rdata holds its last value.
  - Reads have no side effects.
- Read and write in the same cycle to the same register: the read returns the pre-write value.
- reg_rd_en and reg_wr_en may be asserted on back-to-back cycles with no stall.
- Reset asserted mid-operation clears all state immediately. No pulse is captured while rst=1.

Test Plan:
- NUM_SRC=4, ENABLE=0x1, pulse src[0] at cycle 10 -> PENDING=0x1 from cycle 11; irq_out=1 at cycle 12; read 0xC returns 1.
- Pulse src[2] with ENABLE=0x1 -> PENDING=0x4, irq_out stays 0. Then write ENABLE=0x5 -> irq_out=1 one cycle after the write.
- PENDING=0x1, pulse src[0] again -> MISSED=0x1. Write 0x1 to 0x0 -> PENDING=0, irq_out=0 one cycle later. Write 0x1 to 0x8 -> MISSED=0.
- W1C 0x1 to PENDING in the same cycle as a src[0] pulse -> PENDING remains 0x1, MISSED stays 0, irq_out stays 1.
- CNT_W=4: 20 pulse cycles -> COUNT=15, no wrap. Write 0xC in the same cycle as a pulse -> COUNT=1.
- Assert rst asynchronously mid-stream with PENDING=0xF and irq_out=1 -> all registers 0 and irq_out=0 without waiting for a clock edge. A read after release returns 0.
